fetch_sequencer: RTL and testbench

Program-counter sequencer and instruction-RAM read controller for the MIPS fetch stage. Owns the PC and issues one read per cycle to the synchronous instruction RAM (1-cycle read latency). It buffers returned words in a 2-entry skid buffer and presents them to decode over a valid/ready handshake. Jumps redirect the PC, flush buffered words and squash any in-flight read, replacing the free-running combinational address loop with a registered, back-pressure-aware sequencer.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_skid_buffer.sv | 89 ++++++++
 rtl/fetch_sequencer.sv | 140 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the MIPS fetch stage: default address/data widths,
// the default reset program counter and the layout of one buffered fetch entry.
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W   = 4;
    localparam int unsigned FETCH_DATA_W   = 32;
    localparam int unsigned FETCH_RESET_PC = 0;

    // One returned instruction word together with the address it was read from.
    // Modules parameterised away from the default widths declare a local
    // equivalent with the same field order.
    typedef struct packed {
        logic [FETCH_DATA_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// Two-entry in-order buffer between the instruction RAM return path and decode.
// Entry 0 is always the head, so the head outputs come straight from a register
// and do not move while the consumer stalls.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   push_i        write {push_instr_i, push_pc_i} behind the current contents
//   push_instr_i  instruction word to store
//   push_pc_i     address the word was fetched from
//   pop_i         consume the head entry (ignored when empty)
//   flush_i       discard everything (wins over a same-cycle push)
//   head_instr_o  head instruction
//   head_pc_o     head address
//   occ_o         number of valid entries, 0..2
// -----------------------------------------------------------------------------
module fetch_skid_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned DATA_W = FETCH_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_instr_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] head_instr_o,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [1:0]        occ_o
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t     ent0_q, ent0_d;
    entry_t     ent1_q, ent1_d;
    logic [1:0] occ_q, occ_d;
    logic       do_pop;
    logic [1:0] occ_after_pop;

    always_comb begin
        ent0_d        = ent0_q;
        ent1_d        = ent1_q;
        do_pop        = pop_i && (occ_q != 2'd0);
        occ_after_pop = occ_q - {1'b0, do_pop};

        if (do_pop) begin
            ent0_d = ent1_q;
        end

        // The new word lands in the first free slot left after the pop. The
        // sequencer never pushes into a full buffer, so slot 1 is the last one.
        if (push_i) begin
            if (occ_after_pop == 2'd0) begin
                ent0_d.instr = push_instr_i;
                ent0_d.pc    = push_pc_i;
            end else begin
                ent1_d.instr = push_instr_i;
                ent1_d.pc    = push_pc_i;
            end
        end

        occ_d = flush_i ? 2'd0 : (occ_after_pop + {1'b0, push_i});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign head_instr_o = ent0_q.instr;
    assign head_pc_o    = ent0_q.pc;
    assign occ_o        = occ_q;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Program-counter sequencer and instruction-RAM read controller for the fetch
// stage. Issues at most one read per cycle to a synchronous RAM (1-cycle
// latency), buffers returned words in a 2-entry skid buffer and hands them to
// decode over valid/ready. A jump redirects the PC, flushes the buffer and
// squashes any read still returning.
//
// Build option: define FETCH_HALT_EN to add the halt input, which blocks new
// reads while letting buffered/in-flight words drain. Without it the halt port
// does not exist and fetching is never halted.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   jump_en      one-cycle jump request, highest priority
//   jump_addr    jump target, sampled with jump_en
//   mem_addr     RAM read address (the registered fetch PC)
//   mem_re       RAM read enable (combinational issue decision)
//   mem_rdata    RAM data, valid the cycle after mem_re
//   instruction  head-of-buffer instruction
//   instr_valid  instruction/pc/pc_next are valid
//   instr_ready  decode accepts the head this cycle
//   pc           address of the head instruction
//   pc_next      pc + 1, wrapping at 2^ADDR_W
//   halt         (FETCH_HALT_EN only) block new reads
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
    parameter int unsigned       DATA_W   = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next
`ifdef FETCH_HALT_EN
    ,
    input  logic              halt
`endif
);

    logic halt_w;
`ifdef FETCH_HALT_EN
    assign halt_w = halt;
`else
    assign halt_w = 1'b0;
`endif

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_stale_q, inflight_stale_d;

    logic [1:0]        occ;
    logic [DATA_W-1:0] head_instr;
    logic [ADDR_W-1:0] head_pc;
    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        committed;

    assign pop = instr_valid & instr_ready;

    // Slots already spoken for once this cycle's pop is taken: buffered words
    // plus the word returning now. A new read is only issued if its data is
    // guaranteed a slot, which is what keeps the buffer from ever overflowing.
    assign committed = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

    // Held low during reset so the RAM sees no read while the PC is cleared.
    assign issue = reset & ~jump_en & ~halt_w & (committed < 3'd2);

    assign push = inflight_q & ~inflight_stale_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        // Any read that returns in the cycle after a jump belongs to the old
        // instruction stream; tag it so it can never reach the buffer.
        inflight_stale_d = jump_en;

        if (jump_en) begin
            fetch_pc_d = jump_addr;
        end else if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q       <= RESET_PC;
            inflight_q       <= 1'b0;
            inflight_pc_q    <= '0;
            inflight_stale_q <= 1'b0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            inflight_q       <= inflight_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_stale_q <= inflight_stale_d;
        end
    end

    // A jump flushes after the same-cycle pop and push, so a word returning in
    // the jump cycle is dropped and a consumed head still counts as consumed.
    fetch_skid_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i        (clk),
        .rst_ni       (reset),
        .push_i       (push),
        .push_instr_i (mem_rdata),
        .push_pc_i    (inflight_pc_q),
        .pop_i        (pop),
        .flush_i      (jump_en),
        .head_instr_o (head_instr),
        .head_pc_o    (head_pc),
        .occ_o        (occ)
    );

    assign mem_re      = issue;
    assign mem_addr    = fetch_pc_q;
    assign instr_valid = (occ != 2'd0);
    assign instruction = head_instr;
    assign pc          = head_pc;
    assign pc_next     = head_pc + ADDR_W'(1);

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam int AW = 4;
    localparam int DW = 32;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          jump_en = 1'b0;
    logic [AW-1:0] jump_addr = '0;
    logic          instr_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [DW-1:0] mem_rdata = 32'hDEAD_BEEF;
    logic [DW-1:0] instruction;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_next;
`ifdef FETCH_HALT_EN
    logic          halt = 1'b0;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RESET_PC (4'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pc_next     (pc_next)
`ifdef FETCH_HALT_EN
        ,
        .halt        (halt)
`endif
    );

    function automatic logic [DW-1:0] memword(input logic [AW-1:0] a);
        return 32'h1000_0000 + {28'h0, a};
    endfunction

    // Synchronous instruction RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= memword(mem_addr);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: words the buffer holds (by address), reads awaiting
    // return, and the next address to fetch.
    logic [AW-1:0] mbuf[$];
    logic [AW-1:0] mpend[$];
    logic [AW-1:0] mfpc = '0;

    logic          obs_valid, obs_re;
    logic [AW-1:0] obs_pc, obs_addr, obs_pcn;
    logic [DW-1:0] obs_instr;

    task automatic model_reset();
        mbuf.delete();
        mpend.delete();
        mfpc = 4'h0;
    endtask

    task automatic step(input bit j, input logic [AW-1:0] ja, input bit rdy, input bit hl);
        bit            ev, epop, ere;
        logic [AW-1:0] epc, p;
        @(negedge clk);
        jump_en     = j;
        jump_addr   = ja;
        instr_ready = rdy;
`ifdef FETCH_HALT_EN
        halt        = hl;
`endif
        #1;
        ev   = (mbuf.size() != 0);
        epc  = ev ? mbuf[0] : 4'h0;
        epop = ev && rdy;
        ere  = !j && !hl && ((mbuf.size() + mpend.size() - int'(epop)) < 2);
        obs_valid = instr_valid;
        obs_re    = mem_re;
        obs_pc    = pc;
        obs_addr  = mem_addr;
        obs_pcn   = pc_next;
        obs_instr = instruction;
        chk("m_valid", 32'(instr_valid), 32'(ev));
        chk("m_mem_re", 32'(mem_re), 32'(ere));
        chk("m_mem_addr", 32'(mem_addr), 32'(mfpc));
        if (ev) begin
            chk("m_pc", 32'(pc), 32'(epc));
            chk("m_instr", instruction, memword(epc));
            chk("m_pc_next", 32'(pc_next), 32'(4'(epc + 4'h1)));
        end
        @(posedge clk);
        if (epop) void'(mbuf.pop_front());
        if (mpend.size() != 0) begin
            p = mpend.pop_front();
            mbuf.push_back(p);
        end
        if (j) begin
            mbuf.delete();
            mfpc = ja;
        end else if (ere) begin
            mpend.push_back(mfpc);
            mfpc = mfpc + 4'h1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, "_instr"}, instruction, 32'h0);
        chk({tag, "_pc"}, 32'(pc), 32'h0);
        chk({tag, "_pc_next"}, 32'(pc_next), 32'h1);
        chk({tag, "_mem_re"}, 32'(mem_re), 32'h0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    endtask

    typedef struct {
        bit            j;
        logic [AW-1:0] ja;
        bit            rdy;
        bit            ev;
        logic [AW-1:0] epc;
        bit            ere;
        logic [AW-1:0] eaddr;
    } vec_t;

    vec_t tbl[20];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // j, ja, rdy | valid, pc, mem_re, mem_addr
        tbl[0]  = '{0, 4'h0, 1, 0, 4'h0, 1, 4'h0};
        tbl[1]  = '{0, 4'h0, 1, 0, 4'h0, 1, 4'h1};
        tbl[2]  = '{0, 4'h0, 1, 1, 4'h0, 1, 4'h2};
        tbl[3]  = '{0, 4'h0, 0, 1, 4'h1, 0, 4'h3};
        tbl[4]  = '{0, 4'h0, 0, 1, 4'h1, 0, 4'h3};
        tbl[5]  = '{0, 4'h0, 0, 1, 4'h1, 0, 4'h3};
        tbl[6]  = '{0, 4'h0, 0, 1, 4'h1, 0, 4'h3};
        tbl[7]  = '{0, 4'h0, 0, 1, 4'h1, 0, 4'h3};
        tbl[8]  = '{0, 4'h0, 1, 1, 4'h1, 1, 4'h3};
        tbl[9]  = '{0, 4'h0, 1, 1, 4'h2, 1, 4'h4};
        tbl[10] = '{1, 4'h9, 1, 1, 4'h3, 0, 4'h5};
        tbl[11] = '{0, 4'h0, 1, 0, 4'h0, 1, 4'h9};
        tbl[12] = '{0, 4'h0, 1, 0, 4'h0, 1, 4'hA};
        tbl[13] = '{0, 4'h0, 1, 1, 4'h9, 1, 4'hB};
        tbl[14] = '{1, 4'hE, 1, 1, 4'hA, 0, 4'hC};
        tbl[15] = '{1, 4'hF, 1, 0, 4'h0, 0, 4'hE};
        tbl[16] = '{0, 4'h0, 1, 0, 4'h0, 1, 4'hF};
        tbl[17] = '{0, 4'h0, 1, 0, 4'h0, 1, 4'h0};
        tbl[18] = '{0, 4'h0, 1, 1, 4'hF, 1, 4'h1};
        tbl[19] = '{0, 4'h0, 1, 1, 4'h0, 1, 4'h2};

        // Power-on reset.
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("por");
        @(posedge clk);
        #2 reset = 1'b1;

        // Directed stream: start-up latency, back-pressure, jumps, wrap.
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].j, tbl[i].ja, tbl[i].rdy, 1'b0);
            chk($sformatf("t%0d_valid", i), 32'(obs_valid), 32'(tbl[i].ev));
            chk($sformatf("t%0d_mem_re", i), 32'(obs_re), 32'(tbl[i].ere));
            chk($sformatf("t%0d_mem_addr", i), 32'(obs_addr), 32'(tbl[i].eaddr));
            if (tbl[i].ev) begin
                chk($sformatf("t%0d_pc", i), 32'(obs_pc), 32'(tbl[i].epc));
                chk($sformatf("t%0d_instr", i), obs_instr, memword(tbl[i].epc));
                chk($sformatf("t%0d_pc_next", i), 32'(obs_pcn), 32'(4'(tbl[i].epc + 4'h1)));
            end
        end

        // Fill the buffer, then reset asynchronously in the middle of a cycle.
        step(1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk("pre_reset_valid", 32'(obs_valid), 32'h1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("held_rst");
        @(posedge clk);
        #2 reset = 1'b1;
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("restart_mem_re", 32'(obs_re), 32'h1);
        chk("restart_mem_addr", 32'(obs_addr), 32'h0);
        repeat (4) step(1'b0, 4'h0, 1'b1, 1'b0);

`ifdef FETCH_HALT_EN
        // Halt with ready high: in-flight word drains, then the stream pauses.
        step(1'b0, 4'h0, 1'b1, 1'b1);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        chk("halt_drained_valid", 32'(obs_valid), 32'h0);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        repeat (4) step(1'b0, 4'h0, 1'b1, 1'b0);
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            bit            rj, rr, rh;
            logic [AW-1:0] ra;
            rj = ($urandom_range(0, 9) == 0);
            ra = AW'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            rh = HALT_EN && ($urandom_range(0, 5) == 0);
            step(rj, ra, rr, rh);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
